output_requant_fifo: RTL
========================

OUTPUT_REQUANT_FIFO -- requirements
Module: output_requant_fifo

Interface
REQ-001 SHALL have parameter N, default 10: input feature-map side length.
REQ-002 SHALL have parameter K, default 3: convolution kernel side length.
REQ-003 SHALL have parameter P, default 2: pooling window side length.
REQ-004 SHALL have parameter SHIFT, default 8: requantization right-shift amount, range 0..16.
REQ-005 SHALL have parameter DEPTH, default 16: FIFO depth, a power of two, at least 2.
REQ-006 SHALL derive localparam EXPECTED = ((N-K+1)/P)^2 (integer division), which is 16 at the defaults.
REQ-007 SHALL have ports:
  - clk  in  1  the only clock; all logic on its rising edge.
  - global_rst  in  1  synchronous, active-high reset.
  - ce  in  1  frame enable; inputs are ignored while low.
  - data_in  in  32  signed accumulator result from the accelerator.
  - valid_in  in  1  data_in is valid.
  - end_in  in  1  accelerator end-of-frame.
  - relu_en  in  1  static; clamps negative results to 0 when high.
  - dout  out  16  signed requantized word at the FIFO head.
  - dout_valid  out  1  FIFO is not empty.
  - dout_ready  in  1  consumer accepts dout.
  - dout_last  out  1  the head word is the EXPECTED-th word of the frame.
  - full  out  1  FIFO occupancy equals DEPTH.
  - overflow  out  1  sticky; a sample was dropped.
  - count_err  out  1  sticky; the frame ended with a sample count other than EXPECTED.
  - done  out  1  the frame is completely drained.

Function
REQ-008 A sample SHALL be presented when ce=1, valid_in=1 and end_in=0, in state IDLE or COLLECT.
REQ-009 A presented sample SHALL be requantized in this order:
  - if relu_en=1 and data_in<0, result = 0;
  - otherwise add 2^(SHIFT-1), with no add when SHIFT=0;
  - arithmetic right shift by SHIFT;
  - saturate to the range -32768..32767.
  Intermediate arithmetic SHALL be 33-bit signed so the add cannot wrap.
REQ-010 A push SHALL be accepted when (!full || pop) in the same cycle; otherwise the sample is dropped and overflow is set to 1.
REQ-011 Pop SHALL be defined as dout_valid && dout_ready; the FIFO is first-word-fall-through, so dout and dout_last are valid combinationally from the registered head entry whenever dout_valid=1.
REQ-012 Each FIFO entry SHALL store 17 bits: the 16-bit result plus a last flag.
REQ-013 The sample counter SHALL increment on every presented sample, accepted or dropped, and SHALL saturate at EXPECTED+1.
REQ-014 The last flag SHALL be written as 1 when the counter equals EXPECTED-1 at presentation, and 0 otherwise.
REQ-015 The state machine SHALL have states IDLE, COLLECT, DRAIN and DONE, with these transitions:
  - IDLE -> COLLECT on the first presented sample;
  - COLLECT -> DRAIN when ce=1 and end_in=1;
  - DRAIN -> DONE when the FIFO is empty;
  - DONE -> IDLE when ce=0.
REQ-016 On entry to DRAIN, count_err SHALL be set if the counter is not equal to EXPECTED, counting any sample presented in the same cycle.
REQ-017 end_in in IDLE SHALL move the state to DRAIN, with count_err set if EXPECTED is not 0.
REQ-018 valid_in in DRAIN or DONE SHALL be ignored without setting overflow.
REQ-019 done SHALL be 1 exactly while the state is DONE.
REQ-020 Entering IDLE from DONE SHALL clear the counter, while overflow and count_err hold.
REQ-021 When valid_in and end_in are both high, the cycle SHALL be treated as end-only; data_in is ignored.
REQ-022 Read and write pointers SHALL be log2(DEPTH)+1 bits, wrapping naturally; full and empty are derived from the pointer difference.

Reset
REQ-023 When global_rst=1 at a clock edge:
  - state SHALL become IDLE;
  - pointers and counter SHALL become 0;
  - dout_valid, dout_last, full, overflow, count_err and done SHALL be 0 from the next cycle;
  - dout SHALL read 0 while the FIFO is empty.
REQ-024 Reset mid-frame or mid-drain SHALL discard all buffered words, with no pop reported afterwards.
REQ-025 global_rst SHALL take priority over every simultaneous push, pop or end_in.

Verification (defaults N=10, K=3, P=2, SHIFT=8, DEPTH=16)
REQ-026 The bench SHALL cover the following directed scenarios:
  - Reset for 2 cycles -> all outputs 0 and state IDLE.
  - Requantize 0x00000180 -> dout 0x0002; with relu_en=0, 0xFFFFFE80 -> 0xFFFF; with relu_en=1, 0xFFFFFE80 -> 0x0000.
  - Saturate 0x7FFFFFFF -> 0x7FFF and 0x80000000 -> 0x8000.
  - Full frame: 16 samples with dout_ready=0 -> full=1. Then end_in followed by dout_ready=1 -> 16 pops, dout_last=1 only on the 16th, done=1 on the cycle after the FIFO empties, count_err=0.
  - Short frame: 15 samples then end_in -> count_err=1 and dout_last never 1. Then a 17-sample frame with dout_ready=0 -> overflow=1, 17th sample dropped, FIFO holds 16 words.
  - global_rst asserted while 8 words are buffered in DRAIN -> dout_valid=0 next cycle and state IDLE.

Source files
------------

// File: rtl/output_requant_fifo_if.sv
// Handshake bundle between the accelerator, the requant FIFO and the downstream consumer.
// The master side drives samples and dout_ready. The slave side is the FIFO.
interface output_requant_fifo_if;
  logic        ce;
  logic [31:0] data_in;     // signed accumulator word
  logic        valid_in;
  logic        end_in;
  logic        relu_en;
  logic [15:0] dout;        // signed requantized word
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        full;
  logic        overflow;
  logic        count_err;
  logic        done;

  modport master (
    output ce, data_in, valid_in, end_in, relu_en, dout_ready,
    input  dout, dout_valid, dout_last, full, overflow, count_err, done
  );

  modport slave (
    input  ce, data_in, valid_in, end_in, relu_en, dout_ready,
    output dout, dout_valid, dout_last, full, overflow, count_err, done
  );
endinterface

// File: rtl/output_requant_fifo.sv
// Requantizes 32-bit accumulator results to 16 bits and buffers one frame in a FWFT FIFO.
// The FIFO tags the frame's final word and tracks the frame as it collects, drains and completes.
module output_requant_fifo #(
  parameter int N     = 10,
  parameter int K     = 3,
  parameter int P     = 2,
  parameter int SHIFT = 8,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  global_rst,
  output_requant_fifo_if.slave  bus
);

  localparam int EXPECTED = ((N - K + 1) / P) * ((N - K + 1) / P);
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = $clog2(EXPECTED + 2);
  localparam logic [CW-1:0]     CNT_SAT = CW'(EXPECTED + 1);
  localparam logic [CW-1:0]     CNT_EXP = CW'(EXPECTED);
  localparam logic signed [32:0] ROUND  = 33'((1 << SHIFT) >> 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t          state, state_n;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic [16:0]     mem [DEPTH];
  logic            overflow_q, count_err_q;

  logic            empty, full, pop, push, present, end_evt, frame_open, last_flag;
  logic [16:0]     head;
  logic signed [32:0] wide, rounded, shifted;
  logic signed [15:0] rq;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = ((wr_ptr - rd_ptr) == (AW+1)'(DEPTH));
  assign pop        = !empty && bus.dout_ready;
  assign frame_open = (state == S_IDLE) || (state == S_COLLECT);
  // end_in wins over valid_in, so a combined cycle never presents a sample.
  assign present    = bus.ce && bus.valid_in && !bus.end_in && frame_open;
  assign end_evt    = bus.ce && bus.end_in && frame_open;
  assign push       = present && (!full || pop);
  assign last_flag  = (int'(cnt) == EXPECTED - 1);

  // 33-bit intermediates leave room for the rounding add on the largest positive input.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wide = {bus.data_in[31], bus.data_in};
    if (bus.relu_en && bus.data_in[31]) wide = '0;
    rounded = wide + ROUND;
    shifted = rounded >>> SHIFT;
    if (shifted > 33'sd32767)        rq = 16'sh7FFF;
    else if (shifted < -33'sd32768)  rq = 16'sh8000;
    else                             rq = shifted[15:0];
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (end_evt) state_n = S_DRAIN;
                 else if (present) state_n = S_COLLECT;
      S_COLLECT: if (end_evt) state_n = S_DRAIN;
      S_DRAIN:   if (empty) state_n = S_DONE;
      S_DONE:    if (!bus.ce) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (global_rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      overflow_q  <= 1'b0;
      count_err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (present) begin
        if (!push) overflow_q <= 1'b1;
        if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
      end
      if (end_evt && cnt != CNT_EXP) count_err_q <= 1'b1;
      if (state == S_DONE && state_n == S_IDLE) cnt <= '0;
    end
  end

  // NOTE: the storage array is not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {last_flag, rq};
  end

  assign head           = mem[rd_ptr[AW-1:0]];
  assign bus.dout       = empty ? 16'h0000 : head[15:0];
  assign bus.dout_last  = !empty && head[16];
  assign bus.dout_valid = !empty;
  assign bus.full       = full;
  assign bus.overflow   = overflow_q;
  assign bus.count_err  = count_err_q;
  assign bus.done       = (state == S_DONE);

endmodule
